rv_regfile_sb: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard. It also has a handshaked debug access port. It replaces the single-write, two-read core register file for dual-issue and pipelined core configurations. Decode reads operands and busy flags from it, writeback ports write it, and the APB3 debug unit accesses it while the hart is halted.

---
 rtl/rv_regfile_pkg.sv | 24 ++
 rtl/rv_regfile_sb_scoreboard.sv | 80 ++++++++
 rtl/rv_regfile_sb.sv | 174 +++++++++++++++++
 tb/tb_rv_regfile_sb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// -----------------------------------------------------------------------------
// rv_regfile_pkg
// Shared types and helpers for the multi-port register file with scoreboard.
//   - XLEN_DEFAULT / NREGS_DEFAULT : default data width and register count
//   - dbg_state_e                  : debug access FSM states
//   - slice_lo()                   : low bit index of element idx in a packed bus
// -----------------------------------------------------------------------------
package rv_regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef enum logic [1:0] {
        DBG_IDLE   = 2'd0,
        DBG_ACCESS = 2'd1,
        DBG_ACK    = 2'd2
    } dbg_state_e;

    // Packed buses carry element idx at [idx*width +: width].
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rv_regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// rv_regfile_sb_scoreboard
// One pending-write (busy) bit per architectural register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_wr_en      : per write port enable (NWR)
//   i_wr_addr    : packed write addresses (NWR*AW)
//   i_rd_addr    : packed read addresses (NRD*AW)
//   i_iss_en     : instruction issued, mark i_iss_rd busy
//   i_iss_rd     : destination register of the issued instruction
//   i_flush      : clear every busy bit
//   o_rd_busy    : busy flag per read port (combinational)
// Priority on the next value: flush > issue set > writeback clear.
// Register 0 never becomes busy.
// -----------------------------------------------------------------------------
module rv_regfile_sb_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_rd,
    input  logic              i_flush,
    output logic [NRD-1:0]    o_rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Later assignments override earlier ones, which encodes the priority.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWR; p++) begin
            if (i_wr_en[p]) begin
                w_busy_nxt[i_wr_addr[slice_lo(p, AW) +: AW]] = 1'b0;
            end
        end
        if (i_iss_en) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A writeback landing this cycle already satisfies the reader when forwarding.
    always_comb begin
        o_rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            o_rd_busy[r] = r_busy[i_rd_addr[slice_lo(r, AW) +: AW]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (i_wr_en[p] &&
                        (i_wr_addr[slice_lo(p, AW) +: AW] == i_rd_addr[slice_lo(r, AW) +: AW])) begin
                        o_rd_busy[r] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rv_regfile_sb.sv
// -----------------------------------------------------------------------------
// rv_regfile_sb
// Multi-port integer register file with pending-write scoreboard and a
// handshaked debug access port.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data    : NWR packed write ports, highest index wins
//   rd_addr/rd_data/rd_busy  : NRD packed combinational read ports
//   iss_en/iss_rd            : mark destination register busy at issue
//   flush                    : clear all busy bits
//   dbg_halted               : hart halted, debug access allowed
//   dbg_req/we/addr/wdata    : debug request, held by requester until dbg_ack
//   dbg_ack/err/rdata        : one-cycle completion with status and read data
//   dbg_state                : current debug FSM state
// Debug handshake: a request is sampled in IDLE when dbg_req=1; its fields are
// latched then. The access happens in the following ACCESS cycle and dbg_ack
// pulses for exactly one cycle in ACK, two cycles after the request was
// sampled. ACK always returns to IDLE; dbg_req still high in IDLE is a new
// request, so the requester drops it on dbg_ack.
// -----------------------------------------------------------------------------
module rv_regfile_sb
    import rv_regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int NRD    = 2,
    parameter  int NWR    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    input  logic                dbg_halted,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [XLEN-1:0]     dbg_wdata,
    output logic                dbg_ack,
    output logic                dbg_err,
    output logic [XLEN-1:0]     dbg_rdata,
    output logic [1:0]          dbg_state
);

    logic [XLEN-1:0] r_regs [NREGS];

    dbg_state_e      r_state;
    dbg_state_e      w_state_nxt;
    logic            r_dbg_we;
    logic [AW-1:0]   r_dbg_addr;
    logic [XLEN-1:0] r_dbg_wdata;
    logic            r_dbg_err;
    logic [XLEN-1:0] r_dbg_rdata;

    logic            w_capture;
    logic            w_access;
    logic            w_dbg_wr;

    // ---------------- storage ----------------
    // Port writes in ascending index then the debug write: the last
    // non-blocking assignment to an element wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[slice_lo(p, AW) +: AW] != '0)) begin
                    r_regs[wr_addr[slice_lo(p, AW) +: AW]] <= wr_data[slice_lo(p, XLEN) +: XLEN];
                end
            end
            if (w_dbg_wr) begin
                r_regs[r_dbg_addr] <= r_dbg_wdata;
            end
        end
    end

    // ---------------- read ports ----------------
    // r_regs[0] is never written, so address 0 reads 0 without a special case
    // except on the forwarding path.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data[slice_lo(r, XLEN) +: XLEN] = r_regs[rd_addr[slice_lo(r, AW) +: AW]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && (rd_addr[slice_lo(r, AW) +: AW] != '0) &&
                        (wr_addr[slice_lo(p, AW) +: AW] == rd_addr[slice_lo(r, AW) +: AW])) begin
                        rd_data[slice_lo(r, XLEN) +: XLEN] = wr_data[slice_lo(p, XLEN) +: XLEN];
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    rv_regfile_sb_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_rd_addr (rd_addr),
        .i_iss_en  (iss_en),
        .i_iss_rd  (iss_rd),
        .i_flush   (flush),
        .o_rd_busy (rd_busy)
    );

    // ---------------- debug FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DBG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DBG_IDLE:   if (dbg_req) w_state_nxt = DBG_ACCESS;
            DBG_ACCESS: w_state_nxt = DBG_ACK;
            DBG_ACK:    w_state_nxt = DBG_IDLE;
            default:    w_state_nxt = DBG_IDLE;
        endcase
    end

    always_comb begin
        w_capture = (r_state == DBG_IDLE) && dbg_req;
        w_access  = (r_state == DBG_ACCESS);
        w_dbg_wr  = w_access && dbg_halted && r_dbg_we && (r_dbg_addr != '0);
        dbg_ack   = (r_state == DBG_ACK);
        dbg_err   = dbg_ack && r_dbg_err;
        dbg_rdata = r_dbg_rdata;
        dbg_state = r_state;
    end

    // Request fields are latched so the requester may change them after sampling.
    // Read data is the stored value before any same-edge write (no forwarding).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_we    <= 1'b0;
            r_dbg_addr  <= '0;
            r_dbg_wdata <= '0;
            r_dbg_err   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_dbg_we    <= dbg_we;
                r_dbg_addr  <= dbg_addr;
                r_dbg_wdata <= dbg_wdata;
            end
            if (w_access) begin
                r_dbg_err   <= !dbg_halted;
                r_dbg_rdata <= (dbg_halted && !r_dbg_we) ? r_regs[r_dbg_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_rv_regfile_sb.sv
module tb_rv_regfile_sb;
  import rv_regfile_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int BYPASS = 1;
  localparam int AW     = $clog2(NREGS);
  localparam int RW     = NRD*XLEN + NRD + 2;
  localparam int DW     = XLEN + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic                dbg_halted;
  logic                dbg_req;
  logic                dbg_we;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_wdata;
  logic                dbg_ack;
  logic                dbg_err;
  logic [XLEN-1:0]     dbg_rdata;
  logic [1:0]          dbg_state;

  rv_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .dbg_halted(dbg_halted), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];
  int              m_st;        // 0 idle, 1 access, 2 ack
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_wdata;
  int              cyc;

  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] dbg_exp_q[$];
  int            dbg_cyc_q[$];

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [1:0] st_code(input int s);
    dbg_state_e e;
    e = (s == 1) ? DBG_ACCESS : (s == 2) ? DBG_ACK : DBG_IDLE;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_st = 0;
  endtask

  task automatic clr_in();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    dbg_halted = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; dbg_wdata = '0;
  endtask

  // Expected combinational outputs for the inputs currently driven.
  task automatic push_expect();
    logic [RW-1:0]   e;
    logic [XLEN-1:0] d;
    logic            b;
    logic [AW-1:0]   a;
    e = '0;
    for (int r = 0; r < NRD; r++) begin
      a = rd_addr[r*AW +: AW];
      d = m_regs[a];
      b = m_busy[a];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
          d = wr_data[p*XLEN +: XLEN];
          b = 1'b0;
        end
      end
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
      e[NRD + 2 + r*XLEN +: XLEN] = d;
      e[2 + r] = b;
    end
    e[1:0] = st_code(m_st);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc);
  endtask

  // Driver: one clock cycle with the current inputs; advances the model.
  task automatic step();
    logic [XLEN-1:0] nregs [NREGS];
    logic            nbusy [NREGS];
    logic [AW-1:0]   a;
    push_expect();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      nregs = m_regs;
      nbusy = m_busy;
      if (m_st == 1) begin
        dbg_exp_q.push_back({!dbg_halted, (dbg_halted && !m_we) ? m_regs[m_addr] : {XLEN{1'b0}}});
        dbg_cyc_q.push_back(cyc);
      end
      for (int p = 0; p < NWR; p++) begin
        a = wr_addr[p*AW +: AW];
        if (wr_en[p] && a != '0) begin
          nregs[a] = wr_data[p*XLEN +: XLEN];
          nbusy[a] = 1'b0;
        end
      end
      if (m_st == 1 && dbg_halted && m_we && m_addr != '0) nregs[m_addr] = m_wdata;
      if (iss_en && iss_rd != '0) nbusy[iss_rd] = 1'b1;
      if (flush) for (int i = 0; i < NREGS; i++) nbusy[i] = 1'b0;
      m_regs = nregs;
      m_busy = nbusy;
      if (m_st == 0) begin
        if (dbg_req) begin
          m_st = 1; m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
        end
      end else if (m_st == 1) m_st = 2;
      else m_st = 0;
    end
    #1;
    if (m_st == 2) dbg_req = 1'b0;
  endtask

  // Debug transaction, optionally colliding with a port write in the ACCESS cycle.
  task automatic dbg_op(input logic we, input logic [AW-1:0] addr,
                        input logic [XLEN-1:0] wd, input logic halted, input logic clash);
    clr_in();
    dbg_halted = halted; dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    step();
    if (clash) begin
      wr_en = 2'b01;
      wr_addr[AW-1:0] = addr;
      wr_data[XLEN-1:0] = 32'h1234_5678;
    end
    rd_addr = {addr, addr};
    step();
    wr_en = '0;
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [RW-1:0] mon_e;
  logic [DW-1:0] mon_d;
  int            mon_c;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_c = exp_cyc_q.pop_front();
      n_chk++;
      if (mon_c != cyc || {rd_data, rd_busy, dbg_state} !== mon_e) begin
        n_err++;
        $display("FAIL read_port cyc=%0d got=%h exp=%h", cyc, {rd_data, rd_busy, dbg_state}, mon_e);
      end
    end
    if (dbg_ack) begin
      n_chk++;
      if (dbg_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL dbg_ack_spurious cyc=%0d got ack=1 exp ack=0", cyc);
      end else begin
        mon_d = dbg_exp_q.pop_front();
        mon_c = dbg_cyc_q.pop_front();
        if (mon_c != cyc || {dbg_err, dbg_rdata} !== mon_d) begin
          n_err++;
          $display("FAIL dbg_ack cyc=%0d (exp cyc %0d) got err/rdata=%h exp=%h",
                   cyc, mon_c, {dbg_err, dbg_rdata}, mon_d);
        end
      end
    end else if (dbg_cyc_q.size() > 0 && dbg_cyc_q[0] <= cyc) begin
      n_chk++;
      n_err++;
      mon_d = dbg_exp_q.pop_front();
      mon_c = dbg_cyc_q.pop_front();
      $display("FAIL dbg_ack_missing cyc=%0d got ack=0 exp ack=1 err/rdata=%h", cyc, mon_d);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0;
    model_reset();
    clr_in();
    @(posedge clk);
    #1;

    // reset values on every address
    for (int a = 0; a < NREGS / 2; a++) begin
      rd_addr = {AW'(2*a + 1), AW'(2*a)};
      step();
    end
    rst_n = 1'b1;

    // x0 is hardwired
    clr_in();
    wr_en = 2'b01; wr_data[XLEN-1:0] = 32'hDEAD_BEEF;
    step();
    clr_in();
    step();

    // two ports to x5: highest port wins, forwarded same cycle
    wr_en = 2'b11;
    wr_addr = {AW'(5), AW'(5)};
    wr_data = {32'h0000_0022, 32'h0000_0011};
    rd_addr = {AW'(0), AW'(5)};
    step();
    clr_in(); rd_addr = {AW'(5), AW'(5)};
    step();

    // issue marks busy, writeback clears combinationally
    clr_in(); iss_en = 1'b1; iss_rd = 7;
    step();
    clr_in(); rd_addr = {AW'(0), AW'(7)};
    step();
    wr_en = 2'b01; wr_addr[AW-1:0] = 7; wr_data[XLEN-1:0] = 32'h55;
    step();

    // set beats clear; flush beats set
    clr_in(); wr_en = 2'b01; wr_addr[AW-1:0] = 7; wr_data[XLEN-1:0] = 32'h66;
    iss_en = 1'b1; iss_rd = 7;
    step();
    clr_in(); rd_addr = {AW'(9), AW'(7)};
    step();
    iss_en = 1'b1; iss_rd = 9; flush = 1'b1;
    step();
    clr_in(); rd_addr = {AW'(9), AW'(7)};
    step();

    // debug write/read while halted, write colliding with a port write
    dbg_op(1'b1, 3, 32'hA5A5_A5A5, 1'b1, 1'b1);
    dbg_op(1'b0, 3, 32'h0, 1'b1, 1'b0);
    dbg_op(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    // refused while running
    dbg_op(1'b1, 3, 32'h1111_1111, 1'b0, 1'b0);
    dbg_op(1'b0, 3, 32'h0, 1'b0, 1'b0);
    clr_in(); rd_addr = {AW'(0), AW'(3)};
    step();

    // reset in the middle of an access
    clr_in(); dbg_halted = 1'b1; dbg_req = 1'b1; dbg_addr = 3;
    step();
    rst_n = 1'b0;
    model_reset();
    clr_in(); rd_addr = {AW'(0), AW'(3)};
    step();
    step();
    rst_n = 1'b1;
    step();
    dbg_op(1'b0, 3, 32'h0, 1'b1, 1'b0);

    // randomized traffic
    clr_in();
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = ($urandom_range(0, 2) == 0);
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
        wr_data[p*XLEN +: XLEN] = $urandom;
      end
      for (int r = 0; r < NRD; r++)
        rd_addr[r*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
      iss_en = ($urandom_range(0, 3) == 0);
      iss_rd = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      dbg_halted = ($urandom_range(0, 4) != 0);
      if (m_st == 0 && n < 1490 && $urandom_range(0, 4) == 0) begin
        dbg_req = 1'b1;
        dbg_we = $urandom_range(0, 1);
        dbg_addr = AW'($urandom_range(0, 7));
        dbg_wdata = $urandom;
      end
      step();
    end

    // drain
    clr_in();
    for (int n = 0; n < 4; n++) step();
    n_chk++;
    if (dbg_cyc_q.size() != 0) begin
      n_err++;
      $display("FAIL dbg_drain got pending=%0d exp pending=0", dbg_cyc_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
